// File: rtl/vlib_psum_accumulator.sv
// Accumulates a configurable number of signed partial-sum beats, then arithmetic-shifts
// and saturates the total into a registered result held until downstream accepts it.
module vlib_psum_accumulator #(
  parameter int IN_WIDTH  = 11,
  parameter int ACC_WIDTH = 24,
  parameter int OUT_WIDTH = 8,
  parameter int MAX_LEN   = 256
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic [$clog2(MAX_LEN+1)-1:0]        i_cfg_len,
  input  logic [4:0]                          i_cfg_shift,
  input  logic                                i_valid_in,
  input  logic signed [IN_WIDTH-1:0]          i_in,
  output logic                                o_valid_out,
  input  logic                                i_ready_out,
  output logic signed [OUT_WIDTH-1:0]         o_res,
  output logic                                o_busy,
  output logic                                o_err_ovf
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);

  localparam logic signed [OUT_WIDTH-1:0] RES_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] RES_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = ACC_WIDTH'(RES_MAX);
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = ACC_WIDTH'(RES_MIN);

  typedef enum logic {S_IDLE, S_ACC} state_t;

  state_t                       r_state, w_state_next;
  logic signed [ACC_WIDTH-1:0]  r_acc, w_in_ext, w_acc_next, w_shifted;
  logic [LEN_W-1:0]             r_cnt, r_len, w_len_eff, w_cnt_next, w_len_sel;
  logic [4:0]                   r_shift, w_shift_sel;
  logic                         w_complete;
  logic signed [OUT_WIDTH-1:0]  w_res;

  assign w_in_ext  = {{(ACC_WIDTH-IN_WIDTH){i_in[IN_WIDTH-1]}}, i_in};
  assign w_len_eff = (i_cfg_len == '0) ? LEN_W'(1) : i_cfg_len;
  assign o_busy    = (r_state == S_ACC);

  // NOTE: every output gets a default before any branch so no latch is inferred;
  // blocking assignments here let w_cnt_next feed the completion compare below.
  always_comb begin
    w_state_next = r_state;
    w_acc_next   = r_acc;
    w_cnt_next   = r_cnt;
    w_len_sel    = r_len;
    w_shift_sel  = r_shift;
    w_complete   = 1'b0;
    if (i_valid_in) begin
      if (r_state == S_IDLE) begin
        // Config is captured only on the first beat, so mid-result changes are ignored.
        w_acc_next  = w_in_ext;
        w_cnt_next  = LEN_W'(1);
        w_len_sel   = w_len_eff;
        w_shift_sel = i_cfg_shift;
      end else begin
        w_acc_next  = r_acc + w_in_ext;
        w_cnt_next  = r_cnt + LEN_W'(1);
      end
      w_complete   = (w_cnt_next == w_len_sel);
      w_state_next = w_complete ? S_IDLE : S_ACC;
    end
  end

  assign w_shifted = w_acc_next >>> w_shift_sel;

  always_comb begin
    w_res = w_shifted[OUT_WIDTH-1:0];
    if (w_shifted > ACC_MAX)      w_res = RES_MAX;
    else if (w_shifted < ACC_MIN) w_res = RES_MIN;
  end

  // NOTE: sequential state uses non-blocking assignments and a synchronous reset
  // sampled on the clock edge; reset outranks an incoming beat.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_len   <= LEN_W'(1);
      r_shift <= '0;
    end else if (i_valid_in) begin
      r_len   <= w_len_sel;
      r_shift <= w_shift_sel;
      if (w_complete) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        r_acc <= w_acc_next;
        r_cnt <= w_cnt_next;
      end
    end
  end

  // A result that completes while the previous one is still unaccepted is dropped.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_res       <= '0;
      o_valid_out <= 1'b0;
      o_err_ovf   <= 1'b0;
    end else if (w_complete) begin
      if (!o_valid_out || i_ready_out) begin
        o_res       <= w_res;
        o_valid_out <= 1'b1;
      end else begin
        o_err_ovf   <= 1'b1;
      end
    end else if (o_valid_out && i_ready_out) begin
      o_valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vlib_psum_accumulator.sv
// Directed bench for vlib_psum_accumulator: hand-computed vectors checked with
// immediate assertions one time unit after each rising clock edge.
module tb_vlib_psum_accumulator;

  localparam int IN_WIDTH  = 11;
  localparam int ACC_WIDTH = 24;
  localparam int OUT_WIDTH = 8;
  localparam int MAX_LEN   = 256;
  localparam int LEN_W     = $clog2(MAX_LEN + 1);

  logic                         clk = 1'b0;
  logic                         rst;
  logic [LEN_W-1:0]             cfg_len;
  logic [4:0]                   cfg_shift;
  logic                         valid_in;
  logic signed [IN_WIDTH-1:0]   in_beat;
  logic                         valid_out;
  logic                         ready_out;
  logic signed [OUT_WIDTH-1:0]  res;
  logic                         busy;
  logic                         err_ovf;

  int n_vec = 0;
  int n_err = 0;

  vlib_psum_accumulator #(
    .IN_WIDTH (IN_WIDTH),
    .ACC_WIDTH(ACC_WIDTH),
    .OUT_WIDTH(OUT_WIDTH),
    .MAX_LEN  (MAX_LEN)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_cfg_len  (cfg_len),
    .i_cfg_shift(cfg_shift),
    .i_valid_in (valid_in),
    .i_in       (in_beat),
    .o_valid_out(valid_out),
    .i_ready_out(ready_out),
    .o_res      (res),
    .o_busy     (busy),
    .o_err_ovf  (err_ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic signed [IN_WIDTH-1:0] v);
    valid_in = 1'b1;
    in_beat  = v;
    tick();
  endtask

  task automatic idle_cycle();
    valid_in = 1'b0;
    in_beat  = '0;
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    cfg_len   = LEN_W'(1);
    cfg_shift = 5'd0;
    valid_in  = 1'b0;
    in_beat   = '0;
    ready_out = 1'b1;
    tick();
    tick();
    check("rst_res",   $signed(res), 0);
    check("rst_valid", {31'b0, valid_out}, 0);
    check("rst_busy",  {31'b0, busy}, 0);
    check("rst_err",   {31'b0, err_ovf}, 0);
    rst = 1'b0;

    // Four-beat sum, busy across beats 2-4, result one cycle after the last beat
    cfg_len = LEN_W'(4); cfg_shift = 5'd0;
    beat(10);
    check("len4_busy_b2", {31'b0, busy}, 1);
    beat(20);
    beat(30);
    check("len4_no_early_valid", {31'b0, valid_out}, 0);
    check("len4_busy_b4", {31'b0, busy}, 1);
    beat(40);
    check("len4_valid", {31'b0, valid_out}, 1);
    check("len4_res",   $signed(res), 100);
    check("len4_busy_done", {31'b0, busy}, 0);
    idle_cycle();
    check("len4_valid_drop", {31'b0, valid_out}, 0);

    // Saturation and floor shift
    cfg_len = LEN_W'(2); cfg_shift = 5'd0;
    beat(100); beat(100);
    check("sat_pos", $signed(res), 127);
    cfg_shift = 5'd2;
    beat(-300); beat(-300);
    check("sat_neg", $signed(res), -128);
    cfg_shift = 5'd1;
    beat(3); beat(-8);
    check("floor_shift", $signed(res), -3);
    check("floor_valid", {31'b0, valid_out}, 1);
    idle_cycle();

    // Single-beat results back to back with downstream ready
    cfg_len = LEN_W'(1); cfg_shift = 5'd0;
    beat(5);
    check("len1_res_a",   $signed(res), 5);
    check("len1_valid_a", {31'b0, valid_out}, 1);
    beat(-7);
    check("len1_res_b",   $signed(res), -7);
    check("len1_valid_b", {31'b0, valid_out}, 1);
    check("len1_err",     {31'b0, err_ovf}, 0);
    idle_cycle();
    check("len1_valid_drop", {31'b0, valid_out}, 0);

    // Overflow: second result completes while first is still held
    cfg_len = LEN_W'(2); ready_out = 1'b0;
    beat(1); beat(1);
    check("ovf_first_res", $signed(res), 2);
    beat(1); beat(1);
    check("ovf_res_held", $signed(res), 2);
    check("ovf_valid",    {31'b0, valid_out}, 1);
    check("ovf_err",      {31'b0, err_ovf}, 1);
    ready_out = 1'b1;
    idle_cycle();
    check("ovf_valid_drop", {31'b0, valid_out}, 0);
    check("ovf_err_sticky", {31'b0, err_ovf}, 1);

    // Reset mid-result discards the partial sum
    cfg_len = LEN_W'(4);
    beat(1); beat(2);
    check("midrst_busy", {31'b0, busy}, 1);
    rst = 1'b1;
    beat(99);
    rst = 1'b0;
    check("midrst_busy_clr",  {31'b0, busy}, 0);
    check("midrst_valid_clr", {31'b0, valid_out}, 0);
    check("midrst_err_clr",   {31'b0, err_ovf}, 0);
    cfg_len = LEN_W'(2);
    beat(7);
    check("midrst_no_stale", {31'b0, valid_out}, 0);
    beat(8);
    check("midrst_res",   $signed(res), 15);
    check("midrst_valid", {31'b0, valid_out}, 1);
    idle_cycle();

    // Gapped beats with a config change after the first beat
    cfg_len = LEN_W'(3);
    beat(1);
    cfg_len = LEN_W'(1);
    idle_cycle();
    check("gap_busy_hold", {31'b0, busy}, 1);
    beat(2);
    check("gap_no_early_valid", {31'b0, valid_out}, 0);
    idle_cycle();
    beat(3);
    check("gap_res",   $signed(res), 6);
    check("gap_valid", {31'b0, valid_out}, 1);
    idle_cycle();
    check("gap_once_a", {31'b0, valid_out}, 0);
    idle_cycle();
    idle_cycle();
    check("gap_once_b", {31'b0, valid_out}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vlib_psum_accumulator.md
VLIB_PSUM_ACCUMULATOR -- requirements
Module: VLIB_psum_accumulator

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 11, signed width of each adder-tree result beat on IN.
REQ-002 SHALL have parameter ACC_WIDTH, default 24, signed accumulator width; ACC_WIDTH >= IN_WIDTH + $clog2(MAX_LEN) is required.
REQ-003 SHALL have parameter OUT_WIDTH, default 8, signed width of the requantized result RES.
REQ-004 SHALL have parameter MAX_LEN, default 256, maximum number of beats accumulated per result.
REQ-005 SHALL have port CLK, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port RST, input, 1, synchronous active-high reset.
REQ-007 SHALL have port CFG_LEN, input, $clog2(MAX_LEN+1), beats per result; sampled on the first beat of each result.
REQ-008 SHALL have port CFG_SHIFT, input, 5, arithmetic right-shift amount; sampled with CFG_LEN.
REQ-009 SHALL have port VALID_IN, input, 1, IN carries a valid beat this cycle; there is no backpressure toward the source.
REQ-010 SHALL have port IN, input, IN_WIDTH, signed partial sum from the adder tree.
REQ-011 SHALL have port VALID_OUT, output, 1, RES holds a valid result.
REQ-012 SHALL have port READY_OUT, input, 1, downstream accepts RES when VALID_OUT is high.
REQ-013 SHALL have port RES, output, OUT_WIDTH, signed saturated result.
REQ-014 SHALL have port BUSY, output, 1, high while in state ACC.
REQ-015 SHALL have port ERR_OVF, output, 1, sticky flag set when a completed result is dropped.

Function
REQ-016 SHALL implement states IDLE and ACC, with a beat counter cnt and a latched length len.
REQ-017 SHALL, in IDLE on VALID_IN, load acc = sign-extended IN, cnt = 1, and latch len = max(CFG_LEN,1) and the shift value.
REQ-018 SHALL transition IDLE->ACC on the first beat if len > 1, else complete immediately and stay in IDLE.
REQ-019 SHALL, in ACC on VALID_IN, compute acc_next = acc + sign-extended IN and increment cnt; cycles without VALID_IN hold all state.
REQ-020 SHALL complete a result on the beat where cnt reaches len, then return to IDLE, with acc and cnt cleared on the following cycle.
REQ-021 SHALL form the result as acc_next >>> shift (floor) and saturate it to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
REQ-022 SHALL register the result into RES and assert VALID_OUT on the cycle after the completing beat (latency 1).
REQ-023 SHALL hold RES and VALID_OUT stable until a cycle with VALID_OUT && READY_OUT; VALID_OUT then drops unless a new result loads in that same cycle.
REQ-024 SHALL, on completion while VALID_OUT && !READY_OUT, keep the old RES, discard the new result and set ERR_OVF.
REQ-025 SHALL, on completion while VALID_OUT && READY_OUT, load the new RES with VALID_OUT remaining high, and shall not set ERR_OVF.
REQ-026 SHALL ignore CFG_LEN/CFG_SHIFT changes in the middle of a result.
REQ-027 SHALL accept the first beat of the next result on the cycle immediately after the completing beat, with no bubble.

Reset
REQ-028 SHALL, when RST is high at a clock edge, force state IDLE, acc=0, cnt=0, len=1, shift=0, RES=0, VALID_OUT=0, BUSY=0 and ERR_OVF=0, with RST taking priority over VALID_IN.
REQ-029 SHALL discard any partial accumulation when reset is asserted mid-result, with no result emitted.

Verification
REQ-030 SHALL be verified with CFG_LEN=4, SHIFT=0, IN=10,20,30,40 on consecutive cycles -> RES=100, VALID_OUT high one cycle after the fourth beat, BUSY high for beats 2-4.
REQ-031 SHALL be verified with LEN=2, SHIFT=0, IN=100,100 -> RES=127 (saturated); LEN=2, SHIFT=2, IN=-300,-300 -> RES=-128; LEN=2, SHIFT=1, IN=3,-8 -> RES=-3.
REQ-032 SHALL be verified with CFG_LEN=1 and IN=5,-7 on back-to-back cycles with READY_OUT=1 -> RES=5 then -7 on consecutive cycles, VALID_OUT continuous and ERR_OVF=0.
REQ-033 SHALL be verified with LEN=2, READY_OUT=0, four beats of 1 -> RES=2 held, second result dropped and ERR_OVF=1; then READY_OUT=1 -> VALID_OUT drops the next cycle.
REQ-034 SHALL be verified with LEN=4, two beats, RST pulsed, then LEN=2 with beats 7,8 -> RES=15 only, with no stale result.
REQ-035 SHALL be verified with LEN=3 and beats 1,2,3 separated by idle cycles, and CFG_LEN changed to 1 after the first beat -> RES=6 emitted once.
